// File: rtl/wisc_pkg.sv
// Shared WISC pipeline-control definitions: controller states and the
// instruction encodings the control unit cares about.
package wisc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPCODE_W  = 4;
  localparam logic [OPCODE_W-1:0] OPC_HLT   = 4'b1111;
  localparam logic [INSTR_W-1:0]  NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard requests into, and per-stage register controls out of, the pipeline
// control unit.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall_req;
  logic             branch_taken;
  logic             imem_busy;
  logic             dmem_busy;
  logic             halt_id;
  logic             cnt_clr;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output stall_req, branch_taken, imem_busy, dmem_busy, halt_id, cnt_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_bubble, halted, mem_timeout, stall_count
  );

  modport slave (
    input  stall_req, branch_taken, imem_busy, dmem_busy, halt_id, cnt_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_bubble, halted, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Five-stage WISC pipeline control: turns hazard requests into stage enables,
// bubbles and flushes, drains the pipe on HLT, counts stalls, times out dmem.
module pipe_stall_ctrl
  import wisc_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stall_ctrl_if.slave  bus
);
  localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [TW-1:0]   tmo_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;

  // Control row selection; dmem_busy freezes every stage outside HALTED.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;

    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (bus.dmem_busy) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if (state_q != DRAIN) state_d = MEM_WAIT;
    end else if (state_q == DRAIN) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      if (drain_q == '0) state_d = HALTED;
      else               drain_d = drain_q - DW'(1);
    end else begin
      state_d = RUN;
      if (bus.branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (bus.stall_req) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (bus.halt_id) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = DRAIN;
        drain_d      = DW'(DRAIN_CYCLES);
      end else if (bus.imem_busy) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  assign mem_timeout_d = mem_timeout_q |
                         (bus.dmem_busy && (tmo_cnt == TW'(MEM_TIMEOUT - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      drain_q       <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Consecutive dmem busy cycles; any idle cycle restarts the count.
  sat_counter #(.W(TW)) u_tmo_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!bus.dmem_busy),
    .inc_i   (bus.dmem_busy),
    .count_o (tmo_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.cnt_clr),
    .inc_i   (!pc_en && (state_q != HALTED)),
    .count_o (stall_cnt)
  );

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.halted       = (state_q == HALTED);
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.stall_count  = stall_cnt;
endmodule
